pixel_kernel_seq: RTL and testbench

- Sequencer for the MixPix pixel FSM. It scans a kernel of NPIX pixels one at a time: select pixel, pulse start, wait for pixel done, capture the 16-bit result, acknowledge.
- Results are stored in an internal buffer that the Wishbone wrapper reads by index.
- Sits between the Wishbone register block and the pixel FSM, replacing direct software toggling of pxl_start_i/pxl_done_i.

---
 rtl/pixel_kernel_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_pixel_kernel_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_kernel_seq.sv
// pixel_kernel_seq
// Steps the MixPix pixel FSM through a kernel of NPIX pixels. For each pixel
// it selects the pixel, pulses start, waits for done (with an optional
// timeout), captures the result into an internal buffer and completes the
// 4-phase done/ack handshake. The Wishbone side reads results by index.
//
// Optional feature macro: PIXEL_SEQ_LBP_EN (requires NPIX == 9). When it is
// defined, code_o carries the 8-bit LBP code of the last completed kernel.
// Otherwise code_o is tied to 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   go_i           start a kernel scan (ignored unless idle)
//   abort_i        abandon the current scan
//   timeout_i      max wait cycles per pixel, 0 = wait forever
//   pxl_start_o    start pulse to the pixel FSM
//   pxl_ack_o      done acknowledge to the pixel FSM
//   pxl_sel_o      index of the addressed pixel
//   pxl_done_i     done from the pixel FSM
//   pxl_data_i     pixel result
//   busy_o         scan in progress
//   kernel_done_o  one-cycle pulse at scan completion
//   err_o          sticky timeout flag, cleared by the next go_i
//   err_idx_o      index of the pixel that timed out
//   rd_idx_i       result buffer read index
//   rd_data_o      buffer[rd_idx_i], one cycle later; 0 when out of range
//   code_o         LBP code
module pixel_kernel_seq #(
    parameter int unsigned NPIX = 9,
    parameter int unsigned DW   = 16,
    parameter int unsigned TO_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go_i,
    input  logic            abort_i,
    input  logic [TO_W-1:0] timeout_i,
    output logic            pxl_start_o,
    output logic            pxl_ack_o,
    output logic [3:0]      pxl_sel_o,
    input  logic            pxl_done_i,
    input  logic [DW-1:0]   pxl_data_i,
    output logic            busy_o,
    output logic            kernel_done_o,
    output logic            err_o,
    output logic [3:0]      err_idx_o,
    input  logic [3:0]      rd_idx_i,
    output logic [DW-1:0]   rd_data_o,
    output logic [7:0]      code_o
);

    localparam int unsigned IW = 4;
    localparam int unsigned AW = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_START,
        S_WAIT,
        S_CAP,
        S_ACK,
        S_NEXT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [IW-1:0]     err_idx_q, err_idx_d;
    logic              wr_en;
    logic [DW-1:0]     wr_data;

    logic              start_q, ack_q, busy_q, kdone_q;
    logic [DW-1:0]     rd_data_q;
    logic [DW-1:0]     pix_buf_q [NPIX];

    // Next-state, counter, error and buffer-write decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        wr_en     = 1'b0;
        wr_data   = pxl_data_i;

        unique case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    state_d   = S_SEL;
                end
            end
            S_SEL: state_d = S_START;
            S_START: begin
                cnt_d   = timeout_i;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pxl_done_i) begin
                    state_d = S_CAP;
                end else if (timeout_i != '0) begin
                    // Counter at 1 means this decrement reaches zero; <= also
                    // covers a counter loaded as 0 when timeout_i changed mid-wait.
                    if (cnt_q <= TO_W'(1)) begin
                        cnt_d     = '0;
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        wr_en     = 1'b1;
                        wr_data   = '0;
                        state_d   = S_NEXT;
                    end else begin
                        cnt_d = cnt_q - TO_W'(1);
                    end
                end
            end
            S_CAP: begin
                wr_en   = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!pxl_done_i) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == IW'(NPIX - 1)) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_SEL;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops straight to IDLE and leaves the buffer and error flags alone
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            wr_en     = 1'b0;
            err_d     = err_q;
            err_idx_d = err_idx_q;
        end
    end

    // State, datapath and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            start_q   <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            kdone_q   <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < int'(NPIX); i++) begin
                pix_buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            start_q   <= (state_d == S_START);
            ack_q     <= (state_d == S_ACK);
            busy_q    <= (state_d != S_IDLE);
            kdone_q   <= (state_d == S_FIN);
            if (wr_en) begin
                pix_buf_q[AW'(idx_q)] <= wr_data;
            end
            // Reads see the pre-write contents of the buffer
            rd_data_q <= (32'(rd_idx_i) < NPIX) ? pix_buf_q[AW'(rd_idx_i)] : '0;
        end
    end

    assign pxl_start_o   = start_q;
    assign pxl_ack_o     = ack_q;
    assign pxl_sel_o     = idx_q;
    assign busy_o        = busy_q;
    assign kernel_done_o = kdone_q;
    assign err_o         = err_q;
    assign err_idx_o     = err_idx_q;
    assign rd_data_o     = rd_data_q;

`ifdef PIXEL_SEQ_LBP_EN
    logic [7:0] code_d, code_q;

    // Clockwise neighbours 0,1,2,5,8,7,6,3 compared against the centre pixel
    always_comb begin
        code_d    = 8'h00;
        code_d[0] = (pix_buf_q[0] >= pix_buf_q[4]);
        code_d[1] = (pix_buf_q[1] >= pix_buf_q[4]);
        code_d[2] = (pix_buf_q[2] >= pix_buf_q[4]);
        code_d[3] = (pix_buf_q[5] >= pix_buf_q[4]);
        code_d[4] = (pix_buf_q[8] >= pix_buf_q[4]);
        code_d[5] = (pix_buf_q[7] >= pix_buf_q[4]);
        code_d[6] = (pix_buf_q[6] >= pix_buf_q[4]);
        code_d[7] = (pix_buf_q[3] >= pix_buf_q[4]);
    end

    // Buffer is final on entry to FIN, so the code lands with kernel_done_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= 8'h00;
        end else if (state_d == S_FIN) begin
            code_q <= code_d;
        end
    end

    assign code_o = code_q;
`else
    assign code_o = 8'h00;
`endif

endmodule

// File: tb/tb_pixel_kernel_seq.sv
// Testbench for pixel_kernel_seq: behavioural pixel responder plus a
// reference buffer model; directed scan sequence with random pixel data.
module tb_pixel_kernel_seq;

    localparam int unsigned NPIX = 9;
    localparam int unsigned DW   = 16;
    localparam int unsigned TO_W = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            go_i = 1'b0;
    logic            abort_i = 1'b0;
    logic [TO_W-1:0] timeout_i = '0;
    logic            pxl_start_o;
    logic            pxl_ack_o;
    logic [3:0]      pxl_sel_o;
    logic            pxl_done_i = 1'b0;
    logic [DW-1:0]   pxl_data_i = '0;
    logic            busy_o;
    logic            kernel_done_o;
    logic            err_o;
    logic [3:0]      err_idx_o;
    logic [3:0]      rd_idx_i = '0;
    logic [DW-1:0]   rd_data_o;
    logic [7:0]      code_o;

    pixel_kernel_seq #(.NPIX(NPIX), .DW(DW), .TO_W(TO_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go_i          (go_i),
        .abort_i       (abort_i),
        .timeout_i     (timeout_i),
        .pxl_start_o   (pxl_start_o),
        .pxl_ack_o     (pxl_ack_o),
        .pxl_sel_o     (pxl_sel_o),
        .pxl_done_i    (pxl_done_i),
        .pxl_data_i    (pxl_data_i),
        .busy_o        (busy_o),
        .kernel_done_o (kernel_done_o),
        .err_o         (err_o),
        .err_idx_o     (err_idx_o),
        .rd_idx_i      (rd_idx_i),
        .rd_data_o     (rd_data_o),
        .code_o        (code_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pixel responder configuration
    int            done_delay = 1;
    int            hold_after = 0;
    int            stuck_idx  = -1;
    bit            pix_clear  = 1'b0;
    logic [DW-1:0] pix_data [NPIX];

    // Responder / monitor state
    bit   pending = 1'b0;
    int   wait_cnt = 0;
    int   hold_cnt = 0;
    int   cur = 0;
    int   start_sels[$];
    int   kd_cnt = 0;
    int   ack_run = 0;
    int   max_ack_run = 0;
    int   start_while_done = 0;

    // Reference result buffer
    logic [DW-1:0] exp_buf [NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel FSM model: done some cycles after start, held until ack (+hold)
    always begin
        @(posedge clk);
        #1;
        if (!rst_n || pix_clear) begin
            pxl_done_i = 1'b0;
            pending    = 1'b0;
            hold_cnt   = 0;
            ack_run    = 0;
        end else begin
            if (kernel_done_o) kd_cnt++;
            if (pxl_ack_o) ack_run++;
            else ack_run = 0;
            if (ack_run > max_ack_run) max_ack_run = ack_run;
            if (pxl_start_o) begin
                start_sels.push_back(int'(pxl_sel_o));
                if (pxl_done_i) start_while_done++;
                pending  = 1'b1;
                wait_cnt = done_delay;
                cur      = int'(pxl_sel_o);
            end else if (pending) begin
                wait_cnt--;
                if (wait_cnt <= 0) begin
                    pending = 1'b0;
                    if (cur != stuck_idx) begin
                        pxl_done_i = 1'b1;
                        pxl_data_i = pix_data[cur];
                        hold_cnt   = hold_after;
                    end
                end
            end else if (pxl_done_i && pxl_ack_o) begin
                if (hold_cnt == 0) begin
                    pxl_done_i = 1'b0;
                    pxl_data_i = DW'($urandom);
                end else begin
                    hold_cnt--;
                end
            end else if (!pxl_done_i) begin
                pxl_data_i = DW'($urandom);
            end
        end
    end

    // Pulse go and wait (bounded) for kernel_done_o; optional extra go mid-scan
    task automatic run_scan(input int limit, input int go_again_at, output int cycles, output bit seen);
        go_i   = 1'b1;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
            go_i = (cycles == go_again_at);
            if (kernel_done_o) seen = 1'b1;
        end
        go_i = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_idx_i = 4'(i);
            @(posedge clk);
            #1;
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_data_o),
                  (i < int'(NPIX)) ? 32'(exp_buf[i]) : 32'd0);
        end
    endtask

    task automatic check_order(input string tag, input int first, input int last);
        check({tag, "_nstart"}, 32'(start_sels.size()), 32'(last - first + 1));
        for (int i = 0; i < start_sels.size() && i <= last - first; i++) begin
            check($sformatf("%s_sel%0d", tag, i), 32'(start_sels[i]), 32'(first + i));
        end
    endtask

    task automatic new_data(input bit ramp);
        for (int i = 0; i < int'(NPIX); i++) begin
            pix_data[i] = ramp ? DW'(16'h0100 + i) : DW'($urandom);
        end
    endtask

    task automatic clear_mon;
        start_sels.delete();
        kd_cnt           = 0;
        max_ack_run      = 0;
        start_while_done = 0;
    endtask

`ifdef PIXEL_SEQ_LBP_EN
    function automatic logic [7:0] lbp_ref;
        int nb [8] = '{0, 1, 2, 5, 8, 7, 6, 3};
        logic [7:0] c = 8'h00;
        for (int k = 0; k < 8; k++) c[k] = (exp_buf[nb[k]] >= exp_buf[4]);
        return c;
    endfunction
`endif

    int cycles;
    bit seen;
    int kd_before;
    int budget;

    initial begin
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = '0;
        new_data(1'b0);

        // Reset values
        settle(3);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_start", 32'(pxl_start_o), 0);
        check("rst_ack", 32'(pxl_ack_o), 0);
        check("rst_kdone", 32'(kernel_done_o), 0);
        check("rst_err", {31'd0, err_o}, 0);
        check("rst_erridx", 32'(err_idx_o), 0);
        check("rst_sel", 32'(pxl_sel_o), 0);
        check("rst_code", 32'(code_o), 0);
        check("rst_rd", 32'(rd_data_o), 0);
        rst_n = 1'b1;
        settle(2);

        // Ideal pixel: 6 cycles per pixel, go to kernel_done 6*NPIX+1
        done_delay = 1; hold_after = 0; timeout_i = TO_W'(100);
        new_data(1'b0);
        clear_mon();
        run_scan(400, -1, cycles, seen);
        check("ideal_seen", {31'd0, seen}, 1);
        check("ideal_latency", 32'(cycles), 32'(6 * NPIX + 1));
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = pix_data[i];
        settle(2);
        check("ideal_kd", 32'(kd_cnt), 1);
        check_order("ideal", 0, int'(NPIX) - 1);
        read_all("ideal");

        // Nominal: done 3 cycles after start, ramp data, extra go mid-scan ignored
        done_delay = 3;
        new_data(1'b1);
        clear_mon();
        run_scan(600, 10, cycles, seen);
        check("nom_seen", {31'd0, seen}, 1);
        check("nom_busy_fin", 32'(busy_o), 1);
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = pix_data[i];
        settle(2);
        check("nom_kd", 32'(kd_cnt), 1);
        check("nom_err", {31'd0, err_o}, 0);
        check("nom_idle", 32'(busy_o), 0);
        check_order("nom", 0, int'(NPIX) - 1);
        read_all("nom");

        // Timeout on pixel 5
        done_delay = 1; stuck_idx = 5; timeout_i = TO_W'(20);
        new_data(1'b0);
        clear_mon();
        run_scan(800, -1, cycles, seen);
        check("to_seen", {31'd0, seen}, 1);
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = (i == 5) ? '0 : pix_data[i];
        settle(2);
        check("to_err", {31'd0, err_o}, 1);
        check("to_erridx", 32'(err_idx_o), 5);
        check("to_kd", 32'(kd_cnt), 1);
        check_order("to", 0, int'(NPIX) - 1);
        read_all("to");
        stuck_idx = -1;

        // Abort while waiting on pixel 3; go also clears the previous error
        done_delay = 8; timeout_i = TO_W'(100);
        new_data(1'b0);
        clear_mon();
        go_i = 1'b1;
        settle(1);
        go_i = 1'b0;
        settle(1);
        check("ab_err_cleared", {31'd0, err_o}, 0);
        budget = 0;
        while (!(pxl_start_o && pxl_sel_o == 4'd3) && budget < 300) begin
            settle(1);
            budget++;
        end
        check("ab_reach3", {31'd0, (pxl_start_o && pxl_sel_o == 4'd3)}, 1);
        settle(2);
        abort_i = 1'b1;
        settle(1);
        abort_i = 1'b0;
        pix_clear = 1'b1;
        check("ab_busy", 32'(busy_o), 0);
        check("ab_start", 32'(pxl_start_o), 0);
        check("ab_ack", 32'(pxl_ack_o), 0);
        settle(1);
        pix_clear = 1'b0;
        kd_before = kd_cnt;
        for (int i = 0; i < 3; i++) exp_buf[i] = pix_data[i];
        settle(60);
        check("ab_no_kd", 32'(kd_cnt), 32'(kd_before));
        check("ab_kd_zero", 32'(kd_before), 0);
        read_all("ab");

        // Restart after abort begins at pixel 0
        done_delay = 1;
        new_data(1'b0);
        clear_mon();
        run_scan(400, -1, cycles, seen);
        check("rs_seen", {31'd0, seen}, 1);
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = pix_data[i];
        settle(2);
        check_order("rs", 0, int'(NPIX) - 1);
        read_all("rs");
`ifdef PIXEL_SEQ_LBP_EN
        check("rs_code", 32'(code_o), 32'(lbp_ref()));
`else
        check("rs_code", 32'(code_o), 0);
`endif

        // Handshake: done held 10 cycles after ack is first seen
        hold_after = 10;
        new_data(1'b0);
        clear_mon();
        run_scan(1000, -1, cycles, seen);
        check("hs_seen", {31'd0, seen}, 1);
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = pix_data[i];
        settle(2);
        check("hs_ack_len", 32'(max_ack_run), 32'(10 + 1));
        check("hs_start_vs_done", 32'(start_while_done), 0);
        check("hs_kd", 32'(kd_cnt), 1);
        read_all("hs");
        hold_after = 0;

`ifdef PIXEL_SEQ_LBP_EN
        // LBP on the documented sample kernel
        pix_data = '{16'd50, 16'd10, 16'd70, 16'd80, 16'd60, 16'd20, 16'd90, 16'd30, 16'd65};
        clear_mon();
        run_scan(400, -1, cycles, seen);
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = pix_data[i];
        check("lbp_seen", {31'd0, seen}, 1);
        check("lbp_code", 32'(code_o), 32'(lbp_ref()));
        settle(2);
`endif

        // Asynchronous reset while in ACK
        new_data(1'b0);
        clear_mon();
        go_i = 1'b1;
        settle(1);
        go_i = 1'b0;
        budget = 0;
        while (!pxl_ack_o && budget < 100) begin
            settle(1);
            budget++;
        end
        check("rm_in_ack", 32'(pxl_ack_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_ack", 32'(pxl_ack_o), 0);
        check("rm_busy", 32'(busy_o), 0);
        check("rm_rd", 32'(rd_data_o), 0);
        check("rm_sel", 32'(pxl_sel_o), 0);
        settle(2);
        rst_n = 1'b1;
        for (int i = 0; i < int'(NPIX); i++) exp_buf[i] = '0;
        settle(1);
        read_all("rm");
        check("rm_code", 32'(code_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
